// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC-V control unit.
// Opcodes, FSM states, control-field encodings and the decoded control word.
package riscv_ctrl_pkg;

  localparam logic [6:0] RALU   = 7'b0110011;
  localparam logic [6:0] IALU   = 7'b0010011;
  localparam logic [6:0] ILOAD  = 7'b0000011;
  localparam logic [6:0] SSTORE = 7'b0100011;
  localparam logic [6:0] ULOAD  = 7'b0110111;
  localparam logic [6:0] UPC    = 7'b0010111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'b000,
    IMM_I     = 3'b001,
    IMM_SHAMT = 3'b010,
    IMM_S     = 3'b011,
    IMM_U     = 3'b100,
    IMM_B     = 3'b101,
    IMM_J     = 3'b110
  } imm_t;

  typedef enum logic [1:0] {
    WS_ALU = 2'b00,
    WS_RAM = 2'b01,
    WS_PC4 = 2'b10
  } wsel_t;

  typedef enum logic [1:0] {
    PC_4   = 2'b00,
    PC_REL = 2'b01,
    PC_REG = 2'b10
  } pcsel_t;

  typedef enum logic [3:0] {
    CL_ILL,
    CL_RALU,
    CL_IALU,
    CL_UPPER,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LOAD,
    CL_STORE
  } cls_t;

  typedef struct packed {
    logic [3:0] aluop;
    imm_t       imm;
    cls_t       cls;
  } ctrl_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch-side handshake plus the control strobes driven by the unit.
// master = fetch/datapath side, slave = control unit.
interface multicycle_ctrl_if;
  import riscv_ctrl_pkg::*;

  logic       instr_valid;
  logic       instr_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       branch_taken;
  logic [3:0] AluOp;
  imm_t       imm;
  logic       regw;
  wsel_t      writesel;
  logic       ramR;
  logic       ramW;
  logic       incr;
  pcsel_t     pcsel;
  logic       illegal;

  modport master (
    output instr_valid, opcode, funct3,
    output funct7, branch_taken,
    input  instr_ready, AluOp, imm, regw,
    input  writesel, ramR, ramW, incr,
    input  pcsel, illegal
  );

  modport slave (
    input  instr_valid, opcode, funct3,
    input  funct7, branch_taken,
    output instr_ready, AluOp, imm, regw,
    output writesel, ramR, ramW, incr,
    output pcsel, illegal
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of latched opcode/funct fields into a control word.
// Strobe timing is left entirely to the FSM in multicycle_ctrl.
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl
);

  logic unused_f7;
  logic shift;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};
  assign shift = (funct3 == 3'b001) ||
                 (funct3 == 3'b101);

  always_comb begin
    ctrl.aluop = 4'b0000;
    ctrl.imm   = IMM_NONE;
    ctrl.cls   = CL_ILL;
    unique case (1'b1)
      (opcode == RALU): begin
        ctrl.aluop = {funct3, funct7[5]};
        ctrl.cls   = CL_RALU;
      end
      (opcode == IALU): begin
        ctrl.cls = CL_IALU;
        if (shift) begin
          ctrl.aluop = {funct3, funct7[5]};
          ctrl.imm   = IMM_SHAMT;
        end else begin
          ctrl.aluop = {funct3, 1'b0};
          ctrl.imm   = IMM_I;
        end
      end
      (opcode == ULOAD),
      (opcode == UPC): begin
        ctrl.imm = IMM_U;
        ctrl.cls = CL_UPPER;
      end
      (opcode == BRANCH): begin
        ctrl.aluop = {funct3, 1'b1};
        ctrl.imm   = IMM_B;
        ctrl.cls   = CL_BRANCH;
      end
      (opcode == JAL): begin
        ctrl.imm = IMM_J;
        ctrl.cls = CL_JAL;
      end
      (opcode == JALR): begin
        ctrl.imm = IMM_I;
        ctrl.cls = CL_JALR;
      end
      (opcode == ILOAD): begin
        ctrl.imm = IMM_I;
        ctrl.cls = CL_LOAD;
      end
      (opcode == SSTORE): begin
        ctrl.imm = IMM_S;
        ctrl.cls = CL_STORE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: IDLE -> EXEC -> (MEM) -> (WB) -> IDLE.
// Accepts one instruction per handshake and sequences its strobes.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int LOAD_CYCLES  = 2,
  parameter int STORE_CYCLES = 1
) (
  input logic              clock,
  input logic              nreset,
  multicycle_ctrl_if.slave bus
);

  localparam int CW =
    $clog2(max2(LOAD_CYCLES, STORE_CYCLES) + 1);
  localparam logic [CW-1:0] LD_INIT =
    CW'((LOAD_CYCLES > 1) ? LOAD_CYCLES - 2 : 0);
  localparam logic [CW-1:0] ST_INIT =
    CW'((STORE_CYCLES > 1) ? STORE_CYCLES - 2 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    op_q;
  logic [2:0]    f3_q;
  logic [6:0]    f7_q;
  logic          take;
  logic          is_load;
  ctrl_t         ctrl;

  ctrl_decode u_dec (
    .opcode (op_q),
    .funct3 (f3_q),
    .funct7 (f7_q),
    .ctrl   (ctrl)
  );

  assign take    = (state_q == S_IDLE) &&
                   bus.instr_valid;
  assign is_load = (ctrl.cls == CL_LOAD);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        op_q <= bus.opcode;
        f3_q <= bus.funct3;
        f7_q <= bus.funct7;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus.instr_ready = 1'b0;
    bus.AluOp       = 4'b0000;
    bus.imm         = IMM_NONE;
    bus.regw        = 1'b0;
    bus.writesel    = WS_ALU;
    bus.ramR        = 1'b0;
    bus.ramW        = 1'b0;
    bus.incr        = 1'b0;
    bus.pcsel       = PC_4;
    bus.illegal     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        bus.AluOp = ctrl.aluop;
        bus.imm   = ctrl.imm;
        state_d   = S_IDLE;
        unique case (ctrl.cls)
          CL_RALU, CL_IALU, CL_UPPER: begin
            bus.regw = 1'b1;
            bus.incr = 1'b1;
          end
          CL_BRANCH: begin
            bus.incr  = 1'b1;
            bus.pcsel = bus.branch_taken ?
                        PC_REL : PC_4;
          end
          CL_JAL: begin
            bus.regw     = 1'b1;
            bus.writesel = WS_PC4;
            bus.pcsel    = PC_REL;
            bus.incr     = 1'b1;
          end
          CL_JALR: begin
            bus.regw     = 1'b1;
            bus.writesel = WS_PC4;
            bus.pcsel    = PC_REG;
            bus.incr     = 1'b1;
          end
          CL_LOAD: begin
            bus.ramR = 1'b1;
            if (LOAD_CYCLES == 1) begin
              state_d = S_WB;
            end else begin
              cnt_d   = LD_INIT;
              state_d = S_MEM;
            end
          end
          CL_STORE: begin
            bus.ramW = 1'b1;
            if (STORE_CYCLES == 1) begin
              bus.incr = 1'b1;
            end else begin
              cnt_d   = ST_INIT;
              state_d = S_MEM;
            end
          end
          default: begin
            bus.illegal = 1'b1;
            bus.incr    = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        bus.AluOp = ctrl.aluop;
        bus.imm   = ctrl.imm;
        bus.ramR  = is_load;
        bus.ramW  = !is_load;
        // counter holds the remaining MEM cycles after this one
        if (cnt_q == '0) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            bus.incr = 1'b1;
            state_d  = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WB: begin
        bus.regw     = 1'b1;
        bus.writesel = WS_RAM;
        bus.incr     = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (LOAD_CYCLES=3, STORE_CYCLES=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multicycle_ctrl;

  logic clock;
  logic nreset;
  int   n_vec = 0;
  int   n_err = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .LOAD_CYCLES  (3),
    .STORE_CYCLES (2)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_all(
    input string      tag,
    input logic [3:0] alu,
    input logic [2:0] imm,
    input logic       rw,
    input logic [1:0] ws,
    input logic       rr,
    input logic       wr,
    input logic       inc,
    input logic [1:0] pc,
    input logic       ill,
    input logic       rdy
  );
    logic [16:0] obs, exp;
    obs = {bus.AluOp, bus.imm, bus.regw,
           bus.writesel, bus.ramR, bus.ramW,
           bus.incr, bus.pcsel, bus.illegal,
           bus.instr_ready};
    exp = {alu, imm, rw, ws, rr, wr, inc, pc,
           ill, rdy};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %05h expected %05h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_strb(
    input string      tag,
    input logic       rw,
    input logic [1:0] ws,
    input logic       rr,
    input logic       wr,
    input logic       inc,
    input logic [1:0] pc,
    input logic       ill,
    input logic       rdy
  );
    logic [9:0] obs, exp;
    obs = {bus.regw, bus.writesel, bus.ramR,
           bus.ramW, bus.incr, bus.pcsel,
           bus.illegal, bus.instr_ready};
    exp = {rw, ws, rr, wr, inc, pc, ill, rdy};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %03h expected %03h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_imm(
    input string      tag,
    input logic [2:0] imm
  );
    logic [2:0] obs;
    obs = bus.imm;
    n_vec++;
    assert (obs === imm) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b",
             tag, obs, imm);
    end
  endtask

  task automatic issue(
    input logic [6:0] op,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.funct3      = f3;
    bus.funct7      = f7;
    @(negedge clock);
    bus.instr_valid = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk_all(tag, 4'h0, 3'b000, 0, 2'b00,
            0, 0, 0, 2'b00, 0, 1);
  endtask

  initial begin
    nreset           = 1'b0;
    bus.instr_valid  = 1'b0;
    bus.opcode       = 7'h00;
    bus.funct3       = 3'h0;
    bus.funct7       = 7'h00;
    bus.branch_taken = 1'b0;
    @(negedge clock);
    @(negedge clock);
    idle_chk("reset");
    nreset = 1'b1;
    @(negedge clock);
    idle_chk("post_reset");

    // add (sub-form funct7) -> AluOp 0001
    issue(7'b0110011, 3'b000, 7'b0100000);
    chk_all("add_exec", 4'b0001, 3'b000, 1, 2'b00,
            0, 0, 1, 2'b00, 0, 0);
    @(negedge clock);
    idle_chk("add_idle");

    // srai keeps funct7[5], shamt format
    issue(7'b0010011, 3'b101, 7'b0100000);
    chk_all("srai_exec", 4'b1011, 3'b010, 1, 2'b00,
            0, 0, 1, 2'b00, 0, 0);
    @(negedge clock);
    // xori ignores funct7[5], I format
    issue(7'b0010011, 3'b100, 7'b0100000);
    chk_all("xori_exec", 4'b1000, 3'b001, 1, 2'b00,
            0, 0, 1, 2'b00, 0, 0);
    @(negedge clock);
    issue(7'b0110111, 3'b000, 7'b0000000);
    chk_all("lui_exec", 4'b0000, 3'b100, 1, 2'b00,
            0, 0, 1, 2'b00, 0, 0);
    @(negedge clock);
    idle_chk("lui_idle");

    // lw, three read cycles then write-back
    issue(7'b0000011, 3'b010, 7'b0000000);
    chk_all("lw_c1", 4'b0000, 3'b001, 0, 2'b00,
            1, 0, 0, 2'b00, 0, 0);
    @(negedge clock);
    chk_all("lw_c2", 4'b0000, 3'b001, 0, 2'b00,
            1, 0, 0, 2'b00, 0, 0);
    @(negedge clock);
    chk_all("lw_c3", 4'b0000, 3'b001, 0, 2'b00,
            1, 0, 0, 2'b00, 0, 0);
    @(negedge clock);
    chk_strb("lw_wb", 1, 2'b01, 0, 0, 1, 2'b00, 0, 0);
    @(negedge clock);
    idle_chk("lw_idle");

    // sw, two write cycles, incr on the second
    issue(7'b0100011, 3'b010, 7'b0000000);
    chk_strb("sw_c1", 0, 2'b00, 0, 1, 0, 2'b00, 0, 0);
    chk_imm("sw_c1_imm", 3'b011);
    @(negedge clock);
    chk_strb("sw_c2", 0, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    chk_imm("sw_c2_imm", 3'b011);
    @(negedge clock);
    idle_chk("sw_idle");

    // beq taken, then bne not taken
    bus.branch_taken = 1'b1;
    issue(7'b1100011, 3'b000, 7'b0000000);
    chk_all("beq_exec", 4'b0001, 3'b101, 0, 2'b00,
            0, 0, 1, 2'b01, 0, 0);
    @(negedge clock);
    idle_chk("beq_idle");
    bus.branch_taken = 1'b0;
    issue(7'b1100011, 3'b001, 7'b0000000);
    chk_all("bne_exec", 4'b0011, 3'b101, 0, 2'b00,
            0, 0, 1, 2'b00, 0, 0);
    @(negedge clock);
    idle_chk("bne_idle");

    issue(7'b1101111, 3'b000, 7'b0000000);
    chk_strb("jal_exec", 1, 2'b10, 0, 0, 1, 2'b01, 0, 0);
    chk_imm("jal_imm", 3'b110);
    @(negedge clock);
    issue(7'b1100111, 3'b000, 7'b0000000);
    chk_strb("jalr_exec", 1, 2'b10, 0, 0, 1, 2'b10, 0, 0);
    chk_imm("jalr_imm", 3'b001);
    @(negedge clock);
    idle_chk("jalr_idle");

    // unknown opcode, then a normal instruction
    issue(7'b1111111, 3'b000, 7'b0000000);
    chk_strb("ill_exec", 0, 2'b00, 0, 0, 1, 2'b00, 1, 0);
    @(negedge clock);
    idle_chk("ill_idle");
    issue(7'b0110011, 3'b111, 7'b0000000);
    chk_all("and_exec", 4'b1110, 3'b000, 1, 2'b00,
            0, 0, 1, 2'b00, 0, 0);
    @(negedge clock);

    // reset while the load sits in MEM
    issue(7'b0000011, 3'b010, 7'b0000000);
    @(negedge clock);
    chk_strb("lwr_mem", 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    nreset = 1'b0;
    #1;
    idle_chk("lwr_abort");
    @(negedge clock);
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      idle_chk("lwr_no_wb");
    end
    issue(7'b0110011, 3'b000, 7'b0000000);
    chk_all("add2_exec", 4'b0000, 3'b000, 1, 2'b00,
            0, 0, 1, 2'b00, 0, 0);
    @(negedge clock);
    idle_chk("add2_idle");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
